lc3_control_unit: RTL and testbench
===================================

# lc3_control_unit

Instruction sequencing and decode unit (ISDU) for the LC-3 datapath. A Moore FSM that drives every load, gate and mux-select input of the datapath, plus the SRAM strobes. It steps fetch → decode → execute for ADD, AND, NOT, BR, JMP, JSR/JSRR, LDR, STR and PAUSE, with a parameterised memory wait-state counter.

## Interface
- MEM_WAIT, 2 — cycles each SRAM read or write strobe is held; legal range 1–15.
- Clk  in  1  — system clock; all state changes on its rising edge.
- Reset_n  in  1  — asynchronous, active-low; forces state Halted.
- Run  in  1  — level; leaves Halted.
- Continue  in  1  — level; releases PAUSE.
- Opcode  in  4  — IR[15:12].
- IR_5  in  1  — immediate select bit.
- IR_11  in  1  — JSR/JSRR select bit.
- BEN  in  1  — registered branch enable from the datapath.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each — register loads.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each — bus drivers; at most one high in any state.
- PCMUX  out  2 — 00 BUS, 01 adder, 10 PC+1.
- ADDR2MUX  out  2 — 00 SEXT11, 01 SEXT9, 10 SEXT6, 11 zero.
- ALUK  out  2 — 00 ADD, 01 AND, 10 NOT A, 11 pass A.
- ADDR1MUX, SR1MUX, DRMUX, SR2MUX, MIO_EN  out  1 each.
  - ADDR1MUX: 1 = PC, 0 = SR1.
  - SR1MUX: 1 = IR[8:6], 0 = IR[11:9].
  - DRMUX: 1 = R7, 0 = IR[11:9].
  - SR2MUX: 1 = imm5.
  - MIO_EN: 1 = MDR loads from memory.
- Mem_OE, Mem_WE  out  1 each — active-high SRAM read and write strobes.

## Operation
- Every output is a pure function of the state register; all outputs are 0 in any state where they are not listed below.
- Halted: all outputs 0. Go to S18 when Run=1.
- S18: GatePC, LD_MAR, PCMUX=10, LD_PC → S33.
- S33: Mem_OE, MIO_EN held for MEM_WAIT cycles; LD_MDR asserts only in the final cycle → S35.
- S35: GateMDR, LD_IR → S32.
- S32: LD_BEN. Dispatch on Opcode:
  - 0001 → S01; 0101 → S05; 1001 → S09; 0000 → S00; 1100 → S12.
  - 0100 → S04; 0110 → S06; 0111 → S07; 1101 → S13.
  - Any other opcode → S18 (no-op).
- S01/S05/S09: SR1MUX=1, DRMUX=0, SR2MUX=IR_5, GateALU, LD_REG, LD_CC; ALUK 00/01/10 respectively → S18.
- S00: → S22 if BEN, else → S18.
- S22: ADDR1MUX=1, ADDR2MUX=01, PCMUX=01, LD_PC → S18.
- S12: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=11, PCMUX=01, LD_PC → S18.
- S04: GatePC, DRMUX=1, LD_REG; → S21 if IR_11, else → S20.
  - S21: ADDR1MUX=1, ADDR2MUX=00, PCMUX=01, LD_PC → S18.
  - S20: same as S12 → S18. JSRR R7 therefore jumps to the new link value; this is documented behaviour.
- S06/S07: SR1MUX=1, ADDR1MUX=0, ADDR2MUX=10, GateMARMUX, LD_MAR; S06 → S25, S07 → S23.
- S25: identical to S33 → S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC → S18.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR → S16.
- S16: Mem_WE held for MEM_WAIT cycles → S18.
- S13: LD_LED. Hold while Continue=0; when Continue=1 → S13b.
- S13b: hold while Continue=1; when Continue=0 → S18. One PAUSE executes per Continue press.
- Run is sampled only in Halted. Execution never returns to Halted except through reset.

## Timing
- Reset_n low: state = Halted immediately (asynchronous); all outputs 0 within the same cycle. Release is synchronous to the next Clk edge.
- Wait counter: 4 bits. Cleared on entry to S33/S25/S16 and on reset. Exit when count = MEM_WAIT−1. No carry beyond 15.
- Reset asserted mid-wait: the counter and state clear together; Mem_OE/Mem_WE drop without waiting for the next edge.
- Instruction latency in cycles, for W = MEM_WAIT:
  - ADD/AND/NOT: W+4.
  - BR not taken: W+4; BR taken: W+5.
  - JMP: W+4; JSR/JSRR: W+5.
  - LDR: 2W+5; STR: 2W+5.
- No output glitches between states: outputs are decoded from the registered state only.

## Configuration
- CTRL_PAUSE_EN defined: opcode 1101 executes S13/S13b as described above.
- CTRL_PAUSE_EN undefined: S13/S13b are not compiled; opcode 1101 dispatches to S18 as a no-op; LD_LED is tied to 0; Continue is ignored.

## Test plan
- Reset_n=0 mid-S33 with MEM_WAIT=2 → Mem_OE=0 within the same cycle; after release, state stays Halted until Run=1.
- Run=1, Opcode=0001, IR_5=1 → S18, S33×2, S35, S32, S01; S01 shows SR2MUX=1, ALUK=00, LD_REG=1, LD_CC=1; next fetch starts at cycle 7.
- Opcode=0000 with BEN=1 → S22 with PCMUX=01, ADDR2MUX=01, ADDR1MUX=1, LD_PC=1; with BEN=0 → S18 immediately after S00.
- Opcode=0110, MEM_WAIT=3 → S06 (GateMARMUX, LD_MAR), Mem_OE high for exactly 3 cycles, LD_MDR only in the third, then S27 with LD_REG=1, LD_CC=1.
- Opcode=0111 → S23 (ALUK=11, MIO_EN=0, LD_MDR=1), then Mem_WE high for exactly MEM_WAIT cycles, then S18.
- CTRL_PAUSE_EN set, Opcode=1101, Continue held 0 for 10 cycles → LD_LED=1 throughout. Continue pulsed 1 then 0 → exactly one return to S18. Macro unset → 1101 reaches S18 after S32 with LD_LED never 1.

Source files
------------

// File: rtl/lc3_control_unit.sv
// LC-3 instruction sequencing/decode unit: Moore FSM driving datapath loads, gates, mux selects and SRAM strobes.
// Optional macro CTRL_PAUSE_EN compiles the PAUSE (opcode 1101) states S13/S13b.
module lc3_control_unit #(
  parameter int MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       ADDR1MUX,
  output logic       SR1MUX,
  output logic       DRMUX,
  output logic       SR2MUX,
  output logic       MIO_EN,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
    S04, S21, S20, S06, S07, S25, S27, S23, S16
`ifdef CTRL_PAUSE_EN
    , S13, S13B
`endif
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     r_state, w_next;
  logic [3:0] r_wait, w_wait_nxt;
  logic       w_in_wait, w_wait_done;

`ifndef CTRL_PAUSE_EN
  logic w_unused;
  assign w_unused = Continue;
`endif

  // Counter is zero outside wait states, so every entry into S33/S25/S16 starts at 0.
  assign w_in_wait   = (r_state == S33) || (r_state == S25) || (r_state == S16);
  assign w_wait_done = (r_wait == WAIT_LAST);
  assign w_wait_nxt  = (w_in_wait && !w_wait_done) ? r_wait + 4'd1 : 4'd0;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= HALTED;
      r_wait  <= 4'd0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      HALTED: if (Run) w_next = S18;
      S18:    w_next = S33;
      S33:    if (w_wait_done) w_next = S35;
      S35:    w_next = S32;
      S32: begin
        case (Opcode)
          4'b0001: w_next = S01;
          4'b0101: w_next = S05;
          4'b1001: w_next = S09;
          4'b0000: w_next = S00;
          4'b1100: w_next = S12;
          4'b0100: w_next = S04;
          4'b0110: w_next = S06;
          4'b0111: w_next = S07;
`ifdef CTRL_PAUSE_EN
          4'b1101: w_next = S13;
`endif
          default: w_next = S18;
        endcase
      end
      S00:    w_next = BEN ? S22 : S18;
      S04:    w_next = IR_11 ? S21 : S20;
      S06:    w_next = S25;
      S07:    w_next = S23;
      S25:    if (w_wait_done) w_next = S27;
      S23:    w_next = S16;
      S16:    if (w_wait_done) w_next = S18;
`ifdef CTRL_PAUSE_EN
      S13:    if (Continue) w_next = S13B;
      S13B:   if (!Continue) w_next = S18;
`endif
      default: w_next = S18;
    endcase
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = 2'b00; ADDR2MUX = 2'b00; ALUK = 2'b00;
    ADDR1MUX = 1'b0; SR1MUX = 1'b0; DRMUX = 1'b0; SR2MUX = 1'b0;
    MIO_EN = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0;
    case (r_state)
      S18: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1;
      end
      S33, S25: begin
        Mem_OE = 1'b1; MIO_EN = 1'b1; LD_MDR = w_wait_done;
      end
      S35: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S01, S05, S09: begin
        SR1MUX = 1'b1; SR2MUX = IR_5; GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        ALUK = (r_state == S01) ? 2'b00 : (r_state == S05) ? 2'b01 : 2'b10;
      end
      S22, S21: begin
        ADDR1MUX = 1'b1; PCMUX = 2'b01; LD_PC = 1'b1;
        ADDR2MUX = (r_state == S22) ? 2'b01 : 2'b00;
      end
      // JSRR through R7 reads the freshly written link value; accepted behaviour.
      S12, S20: begin
        SR1MUX = 1'b1; ADDR2MUX = 2'b11; PCMUX = 2'b01; LD_PC = 1'b1;
      end
      S04: begin
        GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
      end
      S06, S07: begin
        SR1MUX = 1'b1; ADDR2MUX = 2'b10; GateMARMUX = 1'b1; LD_MAR = 1'b1;
      end
      S27: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S23: begin
        ALUK = 2'b11; GateALU = 1'b1; LD_MDR = 1'b1;
      end
      S16: Mem_WE = 1'b1;
`ifdef CTRL_PAUSE_EN
      S13: LD_LED = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control_unit.sv
// Self-checking bench for lc3_control_unit: fixed vector table, randomized instruction stream
// against an instruction-level model of expected control words, plus reset and PAUSE sequences.
module tb_lc3_control_unit;
  localparam int W = 3;

  logic Clk = 1'b0;
  logic Reset_n, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic ADDR1MUX, SR1MUX, DRMUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE;

  lc3_control_unit #(.MEM_WAIT(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
    .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
    .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED), .GatePC(GatePC), .GateMDR(GateMDR),
    .GateALU(GateALU), .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX),
    .ALUK(ALUK), .ADDR1MUX(ADDR1MUX), .SR1MUX(SR1MUX), .DRMUX(DRMUX), .SR2MUX(SR2MUX),
    .MIO_EN(MIO_EN), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic addr1mux, sr1mux, drmux, sr2mux, mio_en, mem_oe, mem_we;
  } ctl_t;

  ctl_t act;
  assign act = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ALUK,
                ADDR1MUX, SR1MUX, DRMUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE};

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   at_s18  = 1'b0;
  ctl_t exp_q[$];

  task automatic check(input string name, input ctl_t got, input ctl_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Control words, one per datapath step, written from the instruction semantics.
  function automatic ctl_t w_fetch();
    ctl_t c = '0; c.gate_pc = 1; c.ld_mar = 1; c.pcmux = 2'b10; c.ld_pc = 1; return c;
  endfunction
  function automatic ctl_t w_read(input bit last);
    ctl_t c = '0; c.mem_oe = 1; c.mio_en = 1; c.ld_mdr = last; return c;
  endfunction
  function automatic ctl_t w_ir();
    ctl_t c = '0; c.gate_mdr = 1; c.ld_ir = 1; return c;
  endfunction
  function automatic ctl_t w_dec();
    ctl_t c = '0; c.ld_ben = 1; return c;
  endfunction
  function automatic ctl_t w_alu(input logic [1:0] k, input logic imm);
    ctl_t c = '0; c.sr1mux = 1; c.sr2mux = imm; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
    c.aluk = k; return c;
  endfunction
  function automatic ctl_t w_pcrel(input logic [1:0] a2);
    ctl_t c = '0; c.addr1mux = 1; c.addr2mux = a2; c.pcmux = 2'b01; c.ld_pc = 1; return c;
  endfunction
  function automatic ctl_t w_jmp();
    ctl_t c = '0; c.sr1mux = 1; c.addr2mux = 2'b11; c.pcmux = 2'b01; c.ld_pc = 1; return c;
  endfunction
  function automatic ctl_t w_link();
    ctl_t c = '0; c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; return c;
  endfunction
  function automatic ctl_t w_ea();
    ctl_t c = '0; c.sr1mux = 1; c.addr2mux = 2'b10; c.gate_marmux = 1; c.ld_mar = 1; return c;
  endfunction
  function automatic ctl_t w_ldwb();
    ctl_t c = '0; c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; return c;
  endfunction
  function automatic ctl_t w_stdata();
    ctl_t c = '0; c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; return c;
  endfunction
  function automatic ctl_t w_write();
    ctl_t c = '0; c.mem_we = 1; return c;
  endfunction
  function automatic ctl_t w_led();
    ctl_t c = '0; c.ld_led = 1; return c;
  endfunction

  // Expected control-word stream for one instruction, starting at its fetch.
  task automatic build(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
    exp_q.delete();
    exp_q.push_back(w_fetch());
    for (int i = 0; i < W; i++) exp_q.push_back(w_read(i == W - 1));
    exp_q.push_back(w_ir());
    exp_q.push_back(w_dec());
    case (op)
      4'b0001: exp_q.push_back(w_alu(2'b00, ir5));
      4'b0101: exp_q.push_back(w_alu(2'b01, ir5));
      4'b1001: exp_q.push_back(w_alu(2'b10, ir5));
      4'b0000: begin
        exp_q.push_back('0);
        if (ben) exp_q.push_back(w_pcrel(2'b01));
      end
      4'b1100: exp_q.push_back(w_jmp());
      4'b0100: begin
        exp_q.push_back(w_link());
        exp_q.push_back(ir11 ? w_pcrel(2'b00) : w_jmp());
      end
      4'b0110: begin
        exp_q.push_back(w_ea());
        for (int i = 0; i < W; i++) exp_q.push_back(w_read(i == W - 1));
        exp_q.push_back(w_ldwb());
      end
      4'b0111: begin
        exp_q.push_back(w_ea());
        exp_q.push_back(w_stdata());
        for (int i = 0; i < W; i++) exp_q.push_back(w_write());
      end
`ifdef CTRL_PAUSE_EN
      4'b1101: exp_q.push_back(w_led());
`endif
      default: ;
    endcase
  endtask

  task automatic run_instr(input string name, input logic [3:0] op, input logic ir5,
                           input logic ir11, input logic ben);
    build(op, ir5, ir11, ben);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0 || !at_s18) tick();
      check($sformatf("%s op=%h[%0d]", name, op, k), act, exp_q[k]);
      if (k == 0) begin
        Opcode = op; IR_5 = ir5; IR_11 = ir11; BEN = ben;
      end
    end
    at_s18 = 1'b0;
  endtask

  typedef struct {
    logic [3:0] op;
    logic       ir5, ir11, ben;
    int         lat;
    ctl_t       exec;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   cyc;
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0;
    Opcode = 4'h0; IR_5 = 1'b0; IR_11 = 1'b0; BEN = 1'b0;

    tbl.push_back('{4'b0001, 1'b1, 1'b0, 1'b0, W + 4, w_alu(2'b00, 1'b1)});
    tbl.push_back('{4'b0101, 1'b0, 1'b0, 1'b0, W + 4, w_alu(2'b01, 1'b0)});
    tbl.push_back('{4'b1001, 1'b1, 1'b0, 1'b0, W + 4, w_alu(2'b10, 1'b1)});
    tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b1, W + 5, ctl_t'(0)});
    tbl.push_back('{4'b0000, 1'b0, 1'b0, 1'b0, W + 4, ctl_t'(0)});
    tbl.push_back('{4'b1100, 1'b0, 1'b0, 1'b0, W + 4, w_jmp()});
    tbl.push_back('{4'b0100, 1'b0, 1'b1, 1'b0, W + 5, w_link()});
    tbl.push_back('{4'b0100, 1'b0, 1'b0, 1'b0, W + 5, w_link()});
    tbl.push_back('{4'b0110, 1'b0, 1'b0, 1'b0, 2 * W + 5, w_ea()});
    tbl.push_back('{4'b0111, 1'b0, 1'b0, 1'b0, 2 * W + 5, w_ea()});
    tbl.push_back('{4'b1010, 1'b0, 1'b0, 1'b0, W + 3, w_fetch()});
`ifndef CTRL_PAUSE_EN
    tbl.push_back('{4'b1101, 1'b0, 1'b0, 1'b0, W + 3, w_fetch()});
`endif

    #12;
    check("reset_outputs", act, '0);
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halted_no_run", act, '0);
    end
    Run = 1'b1;
    tick();
    check("run_start", act, w_fetch());

    foreach (tbl[i]) begin
      Opcode = tbl[i].op; IR_5 = tbl[i].ir5; IR_11 = tbl[i].ir11; BEN = tbl[i].ben;
      cyc = 0;
      for (int c = 1; c <= 100; c++) begin
        tick();
        if (c == W + 3) check($sformatf("tbl%0d_exec", i), act, tbl[i].exec);
        if (act === w_fetch()) begin
          cyc = c;
          break;
        end
      end
      check_int($sformatf("tbl%0d_latency", i), cyc, tbl[i].lat);
      if (cyc == 0) begin
        $display("FAIL tbl%0d_timeout: no return to fetch within 100 cycles", i);
        $fatal(1, "sequencer stuck");
      end
    end
    at_s18 = 1'b1;

    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
`ifdef CTRL_PAUSE_EN
      if (op == 4'b1101) op = 4'b0001;
`endif
      run_instr("rand", op, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of an SRAM read must drop the strobe immediately.
    tick();
    check("mid_fetch_s18", act, w_fetch());
    Opcode = 4'b0001;
    tick();
    check("mid_wait_oe", act, w_read(1'b0));
    #2 Reset_n = 1'b0;
    #1 check("async_reset_drop", act, '0);
    Run = 1'b0;
    tick();
    Reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_halted", act, '0);
    end
    Run = 1'b1;
    run_instr("after_reset", 4'b0110, 1'b0, 1'b0, 1'b0);
    run_instr("after_reset", 4'b0111, 1'b0, 1'b0, 1'b0);

`ifdef CTRL_PAUSE_EN
    Continue = 1'b0;
    run_instr("pause", 4'b1101, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("pause_hold", act, w_led());
    end
    Continue = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pause_release_wait", act, '0);
    end
    Continue = 1'b0;
    tick();
    check("pause_resume", act, w_fetch());
    tick();
    check("pause_next_read", act, w_read(W == 1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
